ling_add_sequencer: RTL and testbench

Multi-cycle wide adder/subtractor controller built around one instance of the 12-bit Ling prefix adder (module adder: ports cout, sum, a, b, cin).
- Accepts WIDTH-bit operations over a valid/ready handshake.
- Slices each operation into 12-bit chunks, LSB first, one chunk per cycle, chaining carry through a register.
- Returns sum, carry-out and signed overflow over a second valid/ready handshake.
- Sits between an ALU issue stage and a writeback stage.

---
 rtl/ling_add_sequencer_pkg.sv | 17 +
 rtl/ling_add_sequencer_adder.sv | 46 ++++
 rtl/ling_add_sequencer.sv | 111 +++++++++++
 tb/tb_ling_add_sequencer.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ling_add_sequencer_pkg.sv
// Shared types and constants for the chunked Ling-adder sequencer.
package ling_seq_pkg;

   localparam int CHUNK_W = 12;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   // Width of the chunk index; never narrower than one bit.
   function automatic int idx_width(input int num_chunks);
      return (num_chunks > 2) ? $clog2(num_chunks) : 1;
   endfunction

endpackage

// File: rtl/ling_add_sequencer_adder.sv
// 12-bit Ling prefix adder: Kogge-Stone prefix over Ling pseudo-carries H.
module adder (
   output logic        cout,
   output logic [11:0] sum,
   input  logic [11:0] a,
   input  logic [11:0] b,
   input  logic        cin
);

   logic [11:0] g;
   logic [11:0] t;
   logic [11:0] h;
   logic [11:0] p;
   logic [11:0] h_nxt;
   logic [11:0] p_nxt;
   logic [11:0] c;

   assign g = a & b;
   assign t = a | b;

   // H[i] = g[i] | t[i-1] & H[i-1], with cin folded into H[0].
   always_comb begin
      h     = {g[11:1], g[0] | cin};
      p     = {t[10:0], 1'b0};
      h_nxt = h;
      p_nxt = p;
      for (int l = 0; l < 4; l++) begin
         h_nxt = h;
         p_nxt = p;
         for (int i = 0; i < 12; i++) begin
            if (i >= (1 << l)) begin
               h_nxt[i] = h[i] | (p[i] & h[i - (1 << l)]);
               p_nxt[i] = p[i] & p[i - (1 << l)];
            end
         end
         h = h_nxt;
         p = p_nxt;
      end
   end

   // Real carry into bit i is recovered as t[i-1] & H[i-1].
   assign c    = {t[10:0] & h[10:0], cin};
   assign sum  = a ^ b ^ c;
   assign cout = t[11] & h[11];

endmodule

// File: rtl/ling_add_sequencer.sv
// Wide add/sub built from one 12-bit Ling adder, one chunk per cycle, LSB first.
// Handshakes: a transfer happens on a rising edge where valid && ready are both high.
module ling_add_sequencer #(
   parameter  int CHUNK_W    = 12,
   parameter  int NUM_CHUNKS = 4,
   localparam int WIDTH      = CHUNK_W * NUM_CHUNKS
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_sub,
   input  logic             in_cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_cout,
   output logic             out_ovf
);
   import ling_seq_pkg::*;

   localparam int                IDX_W    = idx_width(NUM_CHUNKS);
   localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_CHUNKS - 1);

   if (CHUNK_W != ling_seq_pkg::CHUNK_W) begin : g_bad_chunk_w
      $error("CHUNK_W must match the 12-bit adder");
   end
   if (NUM_CHUNKS < 2 || NUM_CHUNKS > 16) begin : g_bad_num_chunks
      $error("NUM_CHUNKS must be in 2..16");
   end

   state_e             state_q;
   logic [IDX_W-1:0]   idx_q;
   logic               carry_q;
   logic [WIDTH-1:0]   a_q;
   logic [WIDTH-1:0]   b_q;
   logic [WIDTH-1:0]   res_q;
   logic               ovf_q;

   logic [CHUNK_W-1:0] a_chunk;
   logic [CHUNK_W-1:0] b_chunk;
   logic [CHUNK_W-1:0] sum_chunk;
   logic               cout_chunk;
   logic               accept;

   assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
   assign accept    = in_valid && in_ready;
   assign out_valid = (state_q == DONE);
   assign out_sum   = res_q;
   assign out_cout  = carry_q;
   assign out_ovf   = ovf_q;

   always_comb begin
      a_chunk = '0;
      b_chunk = '0;
      for (int i = 0; i < NUM_CHUNKS; i++) begin
         if (idx_q == IDX_W'(i)) begin
            a_chunk = a_q[i*CHUNK_W +: CHUNK_W];
            b_chunk = b_q[i*CHUNK_W +: CHUNK_W];
         end
      end
   end

   adder u_adder (
      .cout (cout_chunk),
      .sum  (sum_chunk),
      .a    (a_chunk),
      .b    (b_chunk),
      .cin  (carry_q)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         idx_q   <= '0;
         carry_q <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         ovf_q   <= 1'b0;
      end else if (accept) begin
         // Subtraction is A + ~B + ~borrow_in.
         a_q     <= in_a;
         b_q     <= in_sub ? ~in_b : in_b;
         carry_q <= in_sub ^ in_cin;
         idx_q   <= '0;
         state_q <= RUN;
      end else begin
         case (state_q)
            IDLE: ;
            RUN: begin
               for (int i = 0; i < NUM_CHUNKS; i++) begin
                  if (idx_q == IDX_W'(i)) res_q[i*CHUNK_W +: CHUNK_W] <= sum_chunk;
               end
               carry_q <= cout_chunk;
               idx_q   <= idx_q + 1'b1;
               if (idx_q == LAST_IDX) begin
                  state_q <= DONE;
                  ovf_q   <= (a_chunk[CHUNK_W-1] == b_chunk[CHUNK_W-1]) &&
                             (sum_chunk[CHUNK_W-1] != a_chunk[CHUNK_W-1]);
               end
            end
            DONE: if (out_ready) state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ling_add_sequencer.sv
// Bench for ling_add_sequencer: directed vector table, multi-cycle corner sequences, random run vs model.
module tb_ling_add_sequencer;

   localparam int W = 48;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] in_a;
   logic [W-1:0] in_b;
   logic         in_sub;
   logic         in_cin;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_sum;
   logic         out_cout;
   logic         out_ovf;

   int tests_run    = 0;
   int tests_failed = 0;

   logic [W-1:0] exp_q[$];

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         sub;
      logic         cin;
      logic [W-1:0] sum;
      logic         cout;
      logic         ovf;
   } vec_t;

   vec_t vecs[11];

   ling_add_sequencer dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_sub    (in_sub),
      .in_cin    (in_cin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .out_cout  (out_cout),
      .out_ovf   (out_ovf)
   );

   // Clock / watchdog
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [W-1:0] rand48();
      logic [63:0] r;
      r = {$urandom(), $urandom()};
      return r[W-1:0];
   endfunction

   function automatic logic [W-1:0] pick_operand();
      case ($urandom_range(0, 7))
         0:       return '1;
         1:       return '0;
         2:       return {1'b0, {(W-1){1'b1}}};
         3:       return {1'b1, {(W-1){1'b0}}};
         default: return rand48();
      endcase
   endfunction

   // Reference: plain integer arithmetic on the whole word.
   function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic sub, input logic cin,
                                 output logic [W-1:0] s, output logic co, output logic ov);
      logic [W+1:0] ua;
      logic [W+1:0] ub;
      logic [W+1:0] uc;
      longint       sa;
      longint       sb;
      longint       r;
      ua = {2'b00, a};
      ub = {2'b00, b};
      uc = {{(W+1){1'b0}}, cin};
      if (!sub) begin
         ua = ua + ub + uc;
         s  = ua[W-1:0];
         co = ua[W];
      end else begin
         s  = a - b - {{(W-1){1'b0}}, cin};
         co = (ua >= ub + uc);
      end
      sa = $signed({{(64-W){a[W-1]}}, a});
      sb = $signed({{(64-W){b[W-1]}}, b});
      r  = sub ? (sa - sb - (cin ? 64'sd1 : 64'sd0)) : (sa + sb + (cin ? 64'sd1 : 64'sd0));
      ov = (r > 64'sh0000_7FFF_FFFF_FFFF) || (r < -64'sh0000_8000_0000_0000);
   endfunction

   // Driver: issue one op, wait for the result, retire it. Inputs change on negedge.
   task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub, input logic cin,
                        output logic [W-1:0] s, output logic co, output logic ov, output int lat);
      int n;
      n = 0;
      while (!in_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("accept_ready", {63'b0, in_ready}, 64'd1);
      in_a     = a;
      in_b     = b;
      in_sub   = sub;
      in_cin   = cin;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      in_a     = rand48();
      in_b     = rand48();
      in_sub   = 1'($urandom_range(0, 1));
      in_cin   = 1'($urandom_range(0, 1));
      lat = 0;
      while (!out_valid && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      s  = out_sum;
      co = out_cout;
      ov = out_ovf;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   initial begin
      logic [W-1:0] s;
      logic         co;
      logic         ov;
      int           lat;
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      logic         rs;
      logic         rc;
      logic [W-1:0] es;
      logic         eco;
      logic         eov;

      vecs[0]  = '{48'h0000_0000_0FFF, 48'h0000_0000_0001, 1'b0, 1'b0, 48'h0000_0000_1000, 1'b0, 1'b0};
      vecs[1]  = '{48'hFFFF_FFFF_FFFF, 48'h0000_0000_0001, 1'b0, 1'b0, 48'h0000_0000_0000, 1'b1, 1'b0};
      vecs[2]  = '{48'h0000_0000_0000, 48'h0000_0000_0001, 1'b1, 1'b0, 48'hFFFF_FFFF_FFFF, 1'b0, 1'b0};
      vecs[3]  = '{48'h0000_0000_0000, 48'h0000_0000_0001, 1'b1, 1'b1, 48'hFFFF_FFFF_FFFE, 1'b0, 1'b0};
      vecs[4]  = '{48'h7FFF_FFFF_FFFF, 48'h0000_0000_0001, 1'b0, 1'b0, 48'h8000_0000_0000, 1'b0, 1'b1};
      vecs[5]  = '{48'h0000_0000_0005, 48'h0000_0000_0003, 1'b1, 1'b0, 48'h0000_0000_0002, 1'b1, 1'b0};
      vecs[6]  = '{48'h8000_0000_0000, 48'h0000_0000_0001, 1'b1, 1'b0, 48'h7FFF_FFFF_FFFF, 1'b1, 1'b1};
      vecs[7]  = '{48'h8000_0000_0000, 48'h8000_0000_0000, 1'b0, 1'b0, 48'h0000_0000_0000, 1'b1, 1'b1};
      vecs[8]  = '{48'h0000_0000_0FFF, 48'h0000_0000_0000, 1'b0, 1'b1, 48'h0000_0000_1000, 1'b0, 1'b0};
      vecs[9]  = '{48'h1234_5678_9ABC, 48'h1111_1111_1111, 1'b0, 1'b0, 48'h2345_6789_ABCD, 1'b0, 1'b0};
      vecs[10] = '{48'h0000_0000_0005, 48'h0000_0000_0003, 1'b1, 1'b1, 48'h0000_0000_0001, 1'b1, 1'b0};

      // Reset
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_a      = '0;
      in_b      = '0;
      in_sub    = 1'b0;
      in_cin    = 1'b0;
      out_ready = 1'b0;
      repeat (2) @(negedge clk);
      check("reset_in_ready",  {63'b0, in_ready},  64'd1);
      check("reset_out_valid", {63'b0, out_valid}, 64'd0);
      check("reset_out_sum",   {16'b0, out_sum},   64'd0);
      check("reset_out_cout",  {63'b0, out_cout},  64'd0);
      check("reset_out_ovf",   {63'b0, out_ovf},   64'd0);
      rst = 1'b0;
      @(negedge clk);

      // Directed vector table
      for (int i = 0; i < 11; i++) begin
         do_op(vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].cin, s, co, ov, lat);
         check($sformatf("vec%0d_latency", i), 64'(lat), 64'd4);
         check($sformatf("vec%0d_sum", i), {16'b0, s}, {16'b0, vecs[i].sum});
         check($sformatf("vec%0d_cout", i), {63'b0, co}, {63'b0, vecs[i].cout});
         check($sformatf("vec%0d_ovf", i), {63'b0, ov}, {63'b0, vecs[i].ovf});
      end

      // Backpressure, then retire and accept on the same edge
      in_a = 48'h0000_0000_0FFF; in_b = 48'h0000_0000_0001; in_sub = 1'b0; in_cin = 1'b0;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      check("bp_first_latency", 64'(lat), 64'd4);
      in_a = 48'h1234_5678_9ABC; in_b = 48'h0000_0000_0ABC; in_sub = 1'b1; in_cin = 1'b0;
      in_valid = 1'b1;
      for (int k = 0; k < 5; k++) begin
         check($sformatf("bp_hold%0d_valid", k), {63'b0, out_valid}, 64'd1);
         check($sformatf("bp_hold%0d_in_ready", k), {63'b0, in_ready}, 64'd0);
         check($sformatf("bp_hold%0d_sum", k), {16'b0, out_sum}, 64'h0000_0000_0000_1000);
         check($sformatf("bp_hold%0d_cout", k), {63'b0, out_cout}, 64'd0);
         check($sformatf("bp_hold%0d_ovf", k), {63'b0, out_ovf}, 64'd0);
         @(negedge clk);
      end
      out_ready = 1'b1;
      #1;
      check("bp_release_in_ready", {63'b0, in_ready}, 64'd1);
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b0;
      check("bp_after_swap_valid", {63'b0, out_valid}, 64'd0);
      lat = 0;
      while (!out_valid && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      check("bp_second_latency", 64'(lat), 64'd4);
      check("bp_second_sum", {16'b0, out_sum}, 64'h0000_1234_5678_9000);
      check("bp_second_cout", {63'b0, out_cout}, 64'd1);
      check("bp_second_ovf", {63'b0, out_ovf}, 64'd0);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check("bp_retired_valid", {63'b0, out_valid}, 64'd0);

      // Reset two cycles into an op that keeps the carry high
      in_a = 48'hFFFF_FFFF_FFFF; in_b = 48'h0000_0000_0001; in_sub = 1'b0; in_cin = 1'b0;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      #1;
      check("midrst_out_valid", {63'b0, out_valid}, 64'd0);
      check("midrst_in_ready", {63'b0, in_ready}, 64'd1);
      check("midrst_out_cout", {63'b0, out_cout}, 64'd0);
      check("midrst_out_sum", {16'b0, out_sum}, 64'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      do_op(48'd5, 48'd3, 1'b0, 1'b0, s, co, ov, lat);
      check("midrst_next_latency", 64'(lat), 64'd4);
      check("midrst_next_sum", {16'b0, s}, 64'd8);
      check("midrst_next_cout", {63'b0, co}, 64'd0);

      // Randomized run against the model
      for (int n = 0; n < 3000; n++) begin
         ra = pick_operand();
         rb = pick_operand();
         rs = 1'($urandom_range(0, 1));
         rc = 1'($urandom_range(0, 1));
         model(ra, rb, rs, rc, es, eco, eov);
         exp_q.push_back(es);
         do_op(ra, rb, rs, rc, s, co, ov, lat);
         check($sformatf("rand%0d_latency", n), 64'(lat), 64'd4);
         check($sformatf("rand%0d_sum a=%0h b=%0h sub=%0b cin=%0b", n, ra, rb, rs, rc),
               {16'b0, s}, {16'b0, exp_q.pop_front()});
         check($sformatf("rand%0d_cout", n), {63'b0, co}, {63'b0, eco});
         check($sformatf("rand%0d_ovf", n), {63'b0, ov}, {63'b0, eov});
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
